// File: rtl/right_shifter_seq.sv
// Multi-cycle 32-bit right shifter. It applies one binary stage per cycle (1, 2, 4, 8, 16) and returns the result 5 cycles after accept.
// Define RIGHT_SHIFTER_ARITH_EN to honour 'arith' (sign fill); without it every shift is logical.
module right_shifter_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        arith,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic        fill_q, fill_d;
  logic        fill_in;

  // The upper amount bits are architecturally ignored.
  logic unused_amount_hi;
  assign unused_amount_hi = ^input2[31:5];

`ifdef RIGHT_SHIFTER_ARITH_EN
  assign fill_in = arith & input1[31];
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill_in      = 1'b0;
`endif

  // Stage k shifts right by 2^k. Stage 4 also covers any out-of-range k.
  function automatic logic [31:0] shr_stage(input logic [31:0] v,
                                            input logic [2:0]  k,
                                            input logic        f);
    case (k)
      3'd0:    return {f, v[31:1]};
      3'd1:    return {{2{f}}, v[31:2]};
      3'd2:    return {{4{f}}, v[31:4]};
      3'd3:    return {{8{f}}, v[31:8]};
      default: return {{16{f}}, v[31:16]};
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    k_d       = k_q;
    work_d    = work_q;
    amt_d     = amt_q;
    fill_d    = fill_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          work_d  = input1;
          amt_d   = input2[4:0];
          fill_d  = fill_in;
          k_d     = 3'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (amt_q[k_q]) work_d = shr_stage(work_q, k_q, fill_q);
        if (k_q == 3'd4) begin
          k_d     = 3'd0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result = work_q;

  // NOTE: sequential state uses non-blocking assignments only.
  // Reset clears the working register as well, so an aborted operation leaves no stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      work_q  <= 32'd0;
      amt_q   <= 5'd0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_right_shifter_seq.sv
// Directed bench for right_shifter_seq. It checks the 5-cycle latency, fill modes, handshake hold and reset abort.
// Expected sign-fill values follow RIGHT_SHIFTER_ARITH_EN, the same macro the design uses.
module tb_right_shifter_seq;

  logic        clk;
  logic        rst_n;
  logic [31:0] input1;
  logic [31:0] input2;
  logic        arith;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_asserts = 0;
  int n_fail    = 0;

  right_shifter_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .input1    (input1),
    .input2    (input2),
    .arith     (arith),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, scramble the inputs, confirm the exact 5-cycle latency, then complete the handshake.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ar, input logic [31:0] exp);
    input1   = a;
    input2   = b;
    arith    = ar;
    in_valid = 1'b1;
    tick();
    chk({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    in_valid = 1'b0;
    input1   = ~a;
    input2   = b ^ 32'h0000_001F;
    arith    = ~ar;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    end
    tick();
    chk({tag, "_valid_at_5"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {30'd0, in_ready, busy}, 32'd2);
  endtask

  logic [31:0] exp_sign4;
  logic [31:0] exp_sign8;
  logic [31:0] held;

  initial begin
`ifdef RIGHT_SHIFTER_ARITH_EN
    exp_sign4 = 32'hF800_0000;
    exp_sign8 = 32'hFFF0_0000;
`else
    exp_sign4 = 32'h0800_0000;
    exp_sign8 = 32'h00F0_0000;
`endif
    rst_n     = 1'b0;
    input1    = 32'd0;
    input2    = 32'd0;
    arith     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);

    run_op("msb_by_31",    32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001);
    run_op("arith_by_4",   32'h8000_0000, 32'd4,         1'b1, exp_sign4);
    run_op("amt_zero",     32'h1234_5678, 32'd0,         1'b0, 32'h1234_5678);
    run_op("upper_ignore", 32'h0000_00F0, 32'hFFFF_FFE3, 1'b0, 32'h0000_001E);
    run_op("arith_by_8",   32'hF000_0000, 32'd8,         1'b1, exp_sign8);
    run_op("pos_arith_16", 32'h7FFF_FFFF, 32'd16,        1'b1, 32'h0000_7FFF);
    run_op("logic_by_1",   32'hA5A5_A5A5, 32'd1,         1'b0, 32'h52D2_D2D2);
    run_op("mix_by_21",    32'hDEAD_BEEF, 32'd21,        1'b0, 32'h0000_06F5);

    // Stall in DONE with a competing request pending.
    input1   = 32'h0000_FF00;
    input2   = 32'd8;
    arith    = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_enter_done", {31'd0, out_valid}, 32'd1);
    held     = 32'h0000_00FF;
    input1   = 32'h0F0F_0F0F;
    input2   = 32'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_result", result, held);
      chk("stall_flags", {29'd0, out_valid, busy, in_ready}, 32'd6);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_release_idle", {29'd0, out_valid, busy, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_new_accept", {29'd0, out_valid, busy, in_ready}, 32'd2);
    for (int i = 0; i < 5; i++) tick();
    chk("stall_new_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_new_result", result, 32'h00F0_F0F0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort mid-SHIFT with an asynchronous reset.
    input1   = 32'hFFFF_FFFF;
    input2   = 32'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 32'd0);
    chk("abort_flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("abort_no_stale", {29'd0, out_valid, busy, in_ready}, 32'd1);
    end

    run_op("after_abort", 32'h0000_0100, 32'd8, 1'b1, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
